scr1_jtag_host: RTL
===================

# scr1_jtag_host

JTAG host engine that drives the initiator side of the scr1 debug TAP. It accepts scan commands on a valid/ready interface and generates TCK/TMS/TDI/TRST_N from the system clock. It samples TDO and returns captured scan data on a response interface. It sits in the SoC-side debug bridge and testbench infrastructure, and connects directly to the TAP controller pins.

## Interface
- `DATA_W`, default 64: maximum scan length in bits; width of `cmd_data` and `rsp_data`.
- `CLK_DIV`, default 2 (legal ≥1): TCK half-period in `clk` cycles.
- `LEN_W`, default $clog2(DATA_W)+1: width of `cmd_len`.
- `clk`  in  1  system clock; all logic is on its rising edge.
- `rst`  in  1  reset, asynchronous assert, active-high.
- `cmd_valid`  in  1  command present.
- `cmd_ready`  out  1  engine can accept a command.
- `cmd_op`  in  2  0=RESET, 1=IR scan, 2=DR scan, 3=IDLE (Run-Test/Idle clocks).
- `cmd_len`  in  LEN_W  scan length, or IDLE TCK count.
- `cmd_data`  in  DATA_W  TDI bits, LSB shifted first.
- `rsp_valid`  out  1  command complete.
- `rsp_ready`  in  1  response consumed.
- `rsp_data`  out  DATA_W  TDO bits, first-shifted bit in bit 0; bits ≥ len are 0.
- `jtag_tck`  out  1  generated TCK.
- `jtag_tms`  out  1  TMS.
- `jtag_tdi`  out  1  TDI.
- `jtag_trst_n`  out  1  TAP reset, active-low.
- `jtag_tdo`  in  1  TDO from the TAP, synchronous to `clk`.

## Operation
- **States:** IDLE, RUN, RESP.
  - IDLE → RUN on `cmd_valid & cmd_ready`.
  - RUN → RESP after the final TCK cycle.
  - RESP → IDLE on `rsp_ready`.
- **`cmd_ready`:** is 1 only in IDLE. Command fields are registered on acceptance.
- **Each TCK cycle:**
  - The low phase lasts CLK_DIV clks, the high phase lasts CLK_DIV clks.
  - TMS and TDI are updated at the clk edge where TCK falls (start of the low phase).
  - TDO is sampled at the clk edge where TCK rises.
- **TAP-position flag `at_rti`:**
  - Reset value is 0.
  - Set to 1 by completion of any op.
  - If an IR, DR or IDLE op starts with `at_rti`=0, one prefix TCK cycle with TMS=0 is inserted.
- **TMS sequences** (k = len; "1,0,0" etc. are consecutive TCK cycles):
  - RESET: TMS 1,1,1,1,1,0 (6 cycles); ends in Run-Test/Idle.
  - DR: TMS 1,0,0, then k shift cycles with TMS=0 except the last with TMS=1, then 1,0. Total k+5 cycles.
  - IR: TMS 1,1,0,0, then k shift cycles as for DR, then 1,0. Total k+6 cycles.
  - IDLE: k cycles with TMS=0. k=0 is legal and completes with no TCK.
- **Shift cycles:**
  - TDI = `cmd_data[i]` in shift cycle i.
  - TDO sampled at the rising edge of shift cycle i goes to `rsp_data[i]`.
  - In non-shift cycles TDI=0 and TDO is ignored.
- **Scan length:** `cmd_len`=0 or `cmd_len`>DATA_W for a scan is treated as DATA_W.
- **`rsp_data`:** is held stable through RESP.
- **Mid-operation reset:** `rst` asserted mid-operation aborts the op immediately. No response is produced.

## Timing
- **Reset values:**
  - `jtag_tck`=0, `jtag_tms`=1, `jtag_tdi`=0, `jtag_trst_n`=0.
  - `cmd_ready`=0, `rsp_valid`=0, `rsp_data`=0.
- **After reset deassertion:**
  - `jtag_trst_n` rises and `cmd_ready` rises at the first clk edge after `rst` falls.
  - The FSM is in IDLE at that edge.
- **Latency:** acceptance at edge e0 and N TCK cycles (including any prefix):
  - First TMS/TDI are driven at e0+1.
  - TCK rises at e0+1+CLK_DIV.
  - The last TCK falls at e0+1+2·CLK_DIV·N, and `rsp_valid` rises at that same edge.
  - For N=0, `rsp_valid` rises at e0+1.
- **Between commands:**
  - TCK is held low; TMS=0 and TDI=0 are held after any op.
  - The TAP is left in Run-Test/Idle after any op.
- **Back-to-back commands:**
  - `rsp_valid` and `rsp_ready` both 1 at edge e → `cmd_ready`=1 at e+1.
  - The minimum gap between commands is therefore one clk.

## Test plan
- Reset, then RESET op, then DR len 32 (data 0) against the scr1 TAP model with IDCODE 0xDEB11001 → `rsp_data`=0xDEB11001. The RESET op is 6 TCK; the DR scan is 37 TCK, with `rsp_valid` at acceptance+1+4·37 clks (CLK_DIV=2).
- IR len 5 data 0x1F → `rsp_data`=0x01 (IR capture pattern). Then DR len 8 data 0xA5 → `rsp_data`=0x4A (1-bit bypass delay).
- IR len 5 data 0x04, then DR len 32 → `rsp_data`=0x22011200.
- IDLE len 0 → `rsp_valid` at acceptance+1 with no TCK edges. IDLE len 3 → exactly 3 TCK pulses with TMS=0.
- Hold `rsp_ready`=0 for 10 clks after completion → `rsp_valid` and `rsp_data` stable, `cmd_ready`=0, TCK static. Then raise `rsp_ready` → `cmd_ready`=1 on the next clk.
- Assert `rst` in the middle of a DR len 32 scan → outputs at their reset values immediately and no response. The next DR scan (without a RESET op) emits the TMS=0 prefix cycle (38 TCK) and returns the IDCODE.

Source files
------------

// File: rtl/scr1_jtag_host.sv
// JTAG host engine: turns RESET/IR/DR/IDLE scan commands into TCK/TMS/TDI waveforms
// for the scr1 debug TAP and returns the captured TDO bits.
module scr1_jtag_host #(
    parameter int unsigned DATA_W  = 64,
    parameter int unsigned CLK_DIV = 2,
    parameter int unsigned LEN_W   = $clog2(DATA_W) + 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [1:0]        cmd_op,
    input  logic [LEN_W-1:0]  cmd_len,
    input  logic [DATA_W-1:0] cmd_data,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DATA_W-1:0] rsp_data,
    output logic              jtag_tck,
    output logic              jtag_tms,
    output logic              jtag_tdi,
    output logic              jtag_trst_n,
    input  logic              jtag_tdo
);

    // Wide enough for the longest IR scan or IDLE count, plus the prefix cycle.
    localparam int unsigned CYC_W =
        (($clog2(DATA_W + 8) > LEN_W) ? $clog2(DATA_W + 8) : LEN_W) + 1;
    localparam int unsigned DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

    localparam logic [1:0] OpReset = 2'd0;
    localparam logic [1:0] OpIr    = 2'd1;
    localparam logic [1:0] OpDr    = 2'd2;

    typedef enum logic [1:0] {StIdle, StRun, StResp} state_t;

    state_t              state_q, state_d;
    logic [1:0]          op_q;
    logic [CYC_W-1:0]    k_q, n_q;
    logic                pre_q;
    logic [CYC_W:0]      h_q;
    logic [DIV_W-1:0]    div_q;
    logic [DATA_W-1:0]   data_q, bit_q, rsp_q;
    logic                tck_q, tms_q, tdi_q, trst_n_q, at_rti_q;

    logic                accept, tick, done;
    logic [CYC_W-1:0]    len_ext, k_c, n_c, cyc_c, cp, hdr;
    logic                pre_c, scan_q, in_pre, shift_c, tms_c, tdi_c;

    assign cmd_ready   = (state_q == StIdle) && trst_n_q;
    assign rsp_valid   = (state_q == StResp);
    assign rsp_data    = rsp_q;
    assign jtag_tck    = tck_q;
    assign jtag_tms    = tms_q;
    assign jtag_tdi    = tdi_q;
    assign jtag_trst_n = trst_n_q;
    assign accept      = cmd_valid && cmd_ready;

    // Command decode at acceptance: effective length and total TCK count.
    always_comb begin
        len_ext = CYC_W'(cmd_len);
        k_c     = len_ext;
        if ((cmd_op == OpIr || cmd_op == OpDr) &&
            (len_ext == '0 || len_ext > CYC_W'(DATA_W))) begin
            k_c = CYC_W'(DATA_W);
        end
        pre_c = (cmd_op != OpReset) && !at_rti_q;
        unique case (cmd_op)
            OpReset: n_c = CYC_W'(6);
            OpIr:    n_c = k_c + CYC_W'(6);
            OpDr:    n_c = k_c + CYC_W'(5);
            default: n_c = k_c;
        endcase
        n_c = n_c + CYC_W'(pre_c);
    end

    // Per-cycle TMS/TDI decode; h_q counts half periods, even = falling edge.
    always_comb begin
        cyc_c   = h_q[CYC_W:1];
        scan_q  = (op_q == OpIr) || (op_q == OpDr);
        in_pre  = pre_q && (cyc_c == '0);
        cp      = cyc_c - CYC_W'(pre_q);
        hdr     = (op_q == OpIr) ? CYC_W'(4) : CYC_W'(3);
        shift_c = scan_q && !in_pre && (cp >= hdr) && (cp < hdr + k_q);
        tdi_c   = shift_c && |(data_q & bit_q);
        unique case (op_q)
            OpReset:    tms_c = (cp < CYC_W'(5));
            OpIr, OpDr: tms_c = !in_pre && ((cp < hdr - CYC_W'(2)) ||
                                            (cp == hdr + k_q - CYC_W'(1)) ||
                                            (cp == hdr + k_q));
            default:    tms_c = 1'b0;
        endcase
        tick = (state_q == StRun) && (div_q == '0);
        done = tick && !h_q[0] && (cyc_c == n_q);
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:  if (accept) state_d = StRun;
            StRun:   if (done) state_d = StResp;
            StResp:  if (rsp_ready) state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            op_q     <= OpReset;
            k_q      <= '0;
            n_q      <= '0;
            pre_q    <= 1'b0;
            h_q      <= '0;
            div_q    <= '0;
            data_q   <= '0;
            bit_q    <= '0;
            rsp_q    <= '0;
            tck_q    <= 1'b0;
            tms_q    <= 1'b1;
            tdi_q    <= 1'b0;
            trst_n_q <= 1'b0;
            at_rti_q <= 1'b0;
        end else begin
            trst_n_q <= 1'b1;
            if (accept) begin
                op_q   <= cmd_op;
                k_q    <= k_c;
                n_q    <= n_c;
                pre_q  <= pre_c;
                h_q    <= '0;
                div_q  <= '0;
                data_q <= cmd_data;
                bit_q  <= DATA_W'(1);
                rsp_q  <= '0;
            end else if (state_q == StRun) begin
                if (tick) begin
                    div_q <= DIV_W'(CLK_DIV - 1);
                    h_q   <= h_q + 1'b1;
                    if (!h_q[0]) begin
                        tck_q <= 1'b0;
                        if (done) begin
                            tms_q    <= 1'b0;
                            tdi_q    <= 1'b0;
                            at_rti_q <= 1'b1;
                        end else begin
                            tms_q <= tms_c;
                            tdi_q <= tdi_c;
                        end
                    end else begin
                        tck_q <= 1'b1;
                        // bit_q marks the current shift position for both TDI and TDO.
                        if (shift_c) begin
                            rsp_q <= rsp_q | (bit_q & {DATA_W{jtag_tdo}});
                            bit_q <= bit_q << 1;
                        end
                    end
                end else begin
                    div_q <= div_q - 1'b1;
                end
            end
        end
    end

endmodule
